// File: rtl/regfile_wb.sv
// regfile_wb
//   Architectural general-purpose register file. Takes the write-back bundle
//   (wb_wreg -> we, wb_wd -> waddr, wb_wdata -> wdata) and serves two decode
//   read ports. Register 0 always reads as zero and ignores writes.
//
// Ports
//   clk          system clock, rising-edge
//   rst          asynchronous reset, active low (0 = in reset)
//   we           write enable
//   waddr        write index
//   wdata        write data
//   re1/raddr1   read port 1 enable / index
//   rdata1       read port 1 data (combinational, bypasses same-cycle write)
//   re2/raddr2   read port 2 enable / index
//   rdata2       read port 2 data (combinational, bypasses same-cycle write)
//   trace_valid  a write committed on the previous edge
//   trace_addr   index of the last committed write (held otherwise)
//   trace_data   data of the last committed write (held otherwise)
//   write_count  number of committed writes, wraps at 2**32
module regfile_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [31:0]       write_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;

  // Writes to index 0 are dropped entirely: no storage, trace or count.
  assign commit = we && (waddr != '0);

  // Entry 0 is only ever loaded with zero, so it collapses to a constant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
      write_count <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_addr  <= waddr;
        trace_data  <= wdata;
        write_count <= write_count + 32'd1;
      end
    end
  end

  // The enable is tested before the index so an X index on a disabled port
  // cannot leak into the data.
  always_comb begin
    rdata1 = '0;
    if (rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb
//   Self-checking bench for regfile_wb. A reference model (array of register
//   values plus last-commit trace and a count) is updated at every edge from
//   the driven inputs; inputs are driven on the falling edge, combinational
//   reads are compared 1 time unit later, registered outputs 1 time unit
//   after the rising edge.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        trace_valid;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic        m_tv;
  logic [4:0]  m_ta;
  logic [31:0] m_td;
  logic [31:0] m_cnt;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (n_checks=%0d)", n_checks);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_tv  = 1'b0;
    m_ta  = 5'd0;
    m_td  = 32'h0;
    m_cnt = 32'h0;
  endtask

  // Expected read result from the read-port rules applied to the model.
  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst !== 1'b1) return 32'h0;
    if (re !== 1'b1) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (we === 1'b1 && waddr == ra) return wdata;
    return m_regs[ra];
  endfunction

  // Advance one rising edge and apply what the edge commits to the model.
  task automatic step();
    @(posedge clk);
    if (rst === 1'b1) begin
      if (we === 1'b1 && waddr != 5'd0) begin
        m_regs[waddr] = wdata;
        m_tv  = 1'b1;
        m_ta  = waddr;
        m_td  = wdata;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_tv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    step();
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    model_reset();
    step();
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    n_checks++;
    if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2: got %h want 0", rdata2); end
    n_checks++;
    if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trace_valid: got %b want 0", trace_valid); end
    n_checks++;
    if (write_count !== 32'h0) begin n_fail++; $display("FAIL reset_write_count: got %0d want 0", write_count); end
    n_checks++;
    if (trace_addr !== 5'd0 || trace_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_trace_fields: got %0d/%h want 0/0", trace_addr, trace_data);
    end
    @(negedge clk);
    we = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_r3_after_release: got %h want 0", rdata1); end
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; re1 = 1'b0;
    step();
    n_checks++;
    if (trace_valid !== 1'b1 || trace_addr !== 5'd5 || trace_data !== 32'h12345678) begin
      n_fail++; $display("FAIL basic_trace: got %b/%0d/%h want 1/5/12345678", trace_valid, trace_addr, trace_data);
    end
    n_checks++;
    if (write_count !== 32'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", write_count); end
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL basic_read: got %h want 12345678", rdata1); end
    step();
    n_checks++;
    if (trace_valid !== 1'b0 || trace_addr !== 5'd5 || trace_data !== 32'h12345678) begin
      n_fail++; $display("FAIL basic_trace_hold: got %b/%0d/%h want 0/5/12345678", trace_valid, trace_addr, trace_data);
    end
  endtask

  task automatic test_bypass();
    write_reg(5'd7, 32'h1);
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h/%h want a5a5a5a5", rdata1, rdata2);
    end
    step();
    @(negedge clk);
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_after_edge: got %h/%h want a5a5a5a5", rdata1, rdata2);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] cnt_before;
    cnt_before = m_cnt;
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h want 0", rdata1); end
    step();
    n_checks++;
    if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL zero_trace_valid: got %b want 0", trace_valid); end
    n_checks++;
    if (write_count !== cnt_before) begin
      n_fail++; $display("FAIL zero_count: got %0d want %0d", write_count, cnt_before);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_next_cycle: got %h want 0", rdata1); end
  endtask

  task automatic test_read_disable();
    write_reg(5'd9, 32'h55);
    re2 = 1'b0; raddr2 = 5'd9;
    #1;
    n_checks++;
    if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL rd_disable: got %h want 0", rdata2); end
    re2 = 1'b1;
    #1;
    n_checks++;
    if (rdata2 !== 32'h55) begin n_fail++; $display("FAIL rd_enable: got %h want 55", rdata2); end
    re1 = 1'b0; raddr1 = 5'bx;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL rd_x_addr_disabled: got %h want 0", rdata1); end
    raddr1 = 5'd0;
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(re1, raddr1);
      e2 = exp_rd(re2, raddr2);
      n_checks++;
      if (rdata1 !== e1) begin n_fail++; $display("FAIL rand_rdata1[%0d]: r%0d got %h want %h", n, raddr1, rdata1, e1); end
      n_checks++;
      if (rdata2 !== e2) begin n_fail++; $display("FAIL rand_rdata2[%0d]: r%0d got %h want %h", n, raddr2, rdata2, e2); end
      step();
      n_checks++;
      if (trace_valid !== m_tv || trace_addr !== m_ta || trace_data !== m_td || write_count !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_trace[%0d]: got %b/%0d/%h/%0d want %b/%0d/%h/%0d", n,
                 trace_valid, trace_addr, trace_data, write_count, m_tv, m_ta, m_td, m_cnt);
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    for (int i = 1; i < 32; i++) begin
      v = 32'(i) * 32'h01010101;
      write_reg(5'(i), v);
    end
    re1 = 1'b1; re2 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i);
      #1;
      n_checks++;
      if (rdata1 !== m_regs[i] || rdata2 !== m_regs[32 - i]) begin
        n_fail++; $display("FAIL fill_read r%0d/r%0d: got %h/%h want %h/%h", i, 32 - i,
                           rdata1, rdata2, m_regs[i], m_regs[32 - i]);
      end
    end
    // Reset lands 2 units after a falling edge, away from any rising edge,
    // with a write pending that must be discarded.
    @(negedge clk);
    #2;
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D;
    raddr1 = 5'd4; raddr2 = 5'd31;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL async_rst_reads: got %h/%h want 0/0", rdata1, rdata2);
    end
    n_checks++;
    if (write_count !== 32'h0 || trace_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_trace: got cnt %0d tv %b want 0/0", write_count, trace_valid);
    end
    @(posedge clk);
    #3;
    we = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++; $display("FAIL async_rst_cleared r%0d/r%0d: got %h/%h want 0/0", i, 31 - i, rdata1, rdata2);
      end
    end
    n_checks++;
    if (write_count !== 32'h0 || trace_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_after_release: got cnt %0d tv %b want 0/0", write_count, trace_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bypass();
    test_zero_reg();
    test_read_disable();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
